fft_bf01_input_buffer: RTL and testbench

FFT_BF01_INPUT_BUFFER -- requirements
Module: fft_bf01_input_buffer

---
 rtl/fft_bf01_input_buffer.sv | 99 +++++++++
 tb/tb_fft_bf01_input_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bf01_input_buffer.sv
// rtl/fft_bf01_input_buffer.sv - pairs first-half and second-half beats of a 512-sample frame for butterfly stage 0/1
module fft_bf01_input_buffer #(
   parameter int LANES = 16,
   parameter int DW    = 10
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               valid_in,
   input  logic signed [LANES-1:0][DW-1:0]    din_real,
   input  logic signed [LANES-1:0][DW-1:0]    din_imag,
   output logic                               valid_out,
   output logic        [8:0]                  base_input_idx,
   output logic signed [LANES-1:0][DW-1:0]    out_real_a,
   output logic signed [LANES-1:0][DW-1:0]    out_imag_a,
   output logic signed [LANES-1:0][DW-1:0]    out_real_b,
   output logic signed [LANES-1:0][DW-1:0]    out_imag_b
);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_PAIR = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [4:0]                cnt_q, cnt_d;
   logic [3:0]                slot;
   logic                      fill_wr;
   logic                      pair_rd;

   // First-half beats parked here until their second-half partner arrives
   logic [LANES-1:0][DW-1:0]  buf_real_q [16];
   logic [LANES-1:0][DW-1:0]  buf_imag_q [16];

   logic                      valid_out_q;
   logic [8:0]                base_q;
   logic [LANES-1:0][DW-1:0]  out_real_a_q, out_imag_a_q, out_real_b_q, out_imag_b_q;

   // Lower four counter bits address the same entry in both phases:
   // written at cnt=k, read back at cnt=16+k
   assign slot    = cnt_q[3:0];
   assign fill_wr = valid_in && (state_q == ST_FILL);
   assign pair_rd = valid_in && (state_q == ST_PAIR);

   // Beat counter and phase advance only on accepted beats
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (valid_in) begin
         cnt_d = cnt_q + 5'd1;
         case (state_q)
            ST_FILL: if (cnt_q == 5'd15) state_d = ST_PAIR;
            ST_PAIR: if (cnt_q == 5'd31) state_d = ST_FILL;
            default: state_d = ST_FILL;
         endcase
      end
   end

   // Buffer storage needs no reset: entries are always rewritten before PAIR reads them
   always_ff @(posedge clk) begin
      if (fill_wr) begin
         buf_real_q[slot] <= din_real;
         buf_imag_q[slot] <= din_imag;
      end
   end

   // FSM state, counter and registered paired-output beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_FILL;
         cnt_q        <= '0;
         valid_out_q  <= 1'b0;
         base_q       <= '0;
         out_real_a_q <= '0;
         out_imag_a_q <= '0;
         out_real_b_q <= '0;
         out_imag_b_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_out_q <= 1'b0;
         if (pair_rd) begin
            valid_out_q  <= 1'b1;
            base_q       <= {1'b0, slot, 4'b0000};
            out_real_a_q <= buf_real_q[slot];
            out_imag_a_q <= buf_imag_q[slot];
            out_real_b_q <= din_real;
            out_imag_b_q <= din_imag;
         end
      end
   end

   assign valid_out      = valid_out_q;
   assign base_input_idx = base_q;
   assign out_real_a     = out_real_a_q;
   assign out_imag_a     = out_imag_a_q;
   assign out_real_b     = out_real_b_q;
   assign out_imag_b     = out_imag_b_q;

endmodule

// File: tb/tb_fft_bf01_input_buffer.sv
// tb/tb_fft_bf01_input_buffer.sv - scoreboard bench for fft_bf01_input_buffer
module tb_fft_bf01_input_buffer;

   localparam int LANES = 16;
   localparam int DW    = 10;

   typedef logic [LANES-1:0][DW-1:0] vec_t;

   typedef struct {
      int         due;
      logic [8:0] base;
      vec_t       ra;
      vec_t       ia;
      vec_t       rb;
      vec_t       ib;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       valid_in = 1'b0;
   vec_t       din_real = '0;
   vec_t       din_imag = '0;
   logic       valid_out;
   logic [8:0] base_input_idx;
   vec_t       out_real_a, out_imag_a, out_real_b, out_imag_b;

   fft_bf01_input_buffer #(.LANES(LANES), .DW(DW)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .valid_in       (valid_in),
      .din_real       (din_real),
      .din_imag       (din_imag),
      .valid_out      (valid_out),
      .base_input_idx (base_input_idx),
      .out_real_a     (out_real_a),
      .out_imag_a     (out_imag_a),
      .out_real_b     (out_real_b),
      .out_imag_b     (out_imag_b)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t q[$];
   exp_t last;
   exp_t mon_e;
   int   pulses = 0;
   int   n_pass = 0;
   int   n_total = 0;

   function automatic void check(string name, logic [159:0] act, logic [159:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // mode 0: ramp imag 0, mode 1: ramp imag 1, mode 2: extremes
   function automatic logic [DW-1:0] smp_re(int mode, int n);
      if (mode == 2) return (n < 256) ? 10'h200 : 10'h1FF;
      return 10'(n - 256);
   endfunction

   function automatic logic [DW-1:0] smp_im(int mode, int n);
      if (mode == 2) return (n < 256) ? 10'h1FF : 10'h200;
      return (mode == 1) ? 10'd1 : 10'd0;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return v;
   endfunction

   task automatic zero_last();
      last.due  = 0;
      last.base = '0;
      last.ra   = '0;
      last.ia   = '0;
      last.rb   = '0;
      last.ib   = '0;
   endtask

   // Monitor: pops the scoreboard on every output beat, checks hold otherwise
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         pulses++;
         if (q.size() == 0) begin
            check("spurious_valid_out", 160'd1, 160'd0);
         end else begin
            mon_e = q.pop_front();
            check("latency", 160'(cyc), 160'(mon_e.due));
            check("base", 160'(base_input_idx), 160'(mon_e.base));
            check("real_a", out_real_a, mon_e.ra);
            check("imag_a", out_imag_a, mon_e.ia);
            check("real_b", out_real_b, mon_e.rb);
            check("imag_b", out_imag_b, mon_e.ib);
            last = mon_e;
         end
      end else begin
         check("valid_out_low", 160'(valid_out), 160'd0);
         if (q.size() > 0 && q[0].due <= cyc) begin
            check("missing_valid_out", 160'd0, 160'd1);
            void'(q.pop_front());
         end
         check("hold_base", 160'(base_input_idx), 160'(last.base));
         check("hold_real_a", out_real_a, last.ra);
         check("hold_imag_a", out_imag_a, last.ia);
         check("hold_real_b", out_real_b, last.rb);
         check("hold_imag_b", out_imag_b, last.ib);
      end
   end

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         valid_in = 1'b0;
         din_real = rnd_vec();
         din_imag = rnd_vec();
      end
   endtask

   task automatic beat(int mode, int k);
      exp_t e;
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      for (int j = 0; j < LANES; j++) begin
         din_real[j] = smp_re(mode, 16 * k + j);
         din_imag[j] = smp_im(mode, 16 * k + j);
      end
      if (k >= 16) begin
         e.due  = cyc + 1;
         e.base = 9'(16 * (k - 16));
         for (int j = 0; j < LANES; j++) begin
            e.ra[j] = smp_re(mode, 16 * (k - 16) + j);
            e.ia[j] = smp_im(mode, 16 * (k - 16) + j);
            e.rb[j] = smp_re(mode, 16 * k + j);
            e.ib[j] = smp_im(mode, 16 * k + j);
         end
         q.push_back(e);
      end
   endtask

   task automatic send_frame(int mode, bit gap);
      for (int k = 0; k < 32; k++) begin
         beat(mode, k);
         if (gap) idle(1);
      end
   endtask

   task automatic reset_pulse(int n);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      q.delete();
      zero_last();
      repeat (n) begin
         valid_in = 1'($urandom_range(0, 1));
         din_real = rnd_vec();
         din_imag = rnd_vec();
         @(posedge clk);
         #1;
      end
      rstn     = 1'b1;
      valid_in = 1'b0;
   endtask

   int p0;

   initial begin
      zero_last();
      reset_pulse(6);
      idle(2);

      // single ramp frame
      p0 = pulses;
      send_frame(0, 1'b0);
      idle(3);
      check("frame1_pulses", 160'(pulses - p0), 160'd16);
      check("frame1_drained", 160'(q.size()), 160'd0);
      check("frame1_last_base", 160'(base_input_idx), 160'd240);
      check("frame1_last_a15", 160'(out_real_a[15]), 160'h3FF);
      check("frame1_last_b15", 160'(out_real_b[15]), 160'd255);

      // back-to-back frames, second with imag=1
      p0 = pulses;
      send_frame(0, 1'b0);
      send_frame(1, 1'b0);
      idle(3);
      check("b2b_pulses", 160'(pulses - p0), 160'd32);
      check("b2b_drained", 160'(q.size()), 160'd0);
      check("b2b_imag_a15", 160'(out_imag_a[15]), 160'd1);
      check("b2b_imag_b0", 160'(out_imag_b[0]), 160'd1);

      // valid_in toggling every cycle
      p0 = pulses;
      send_frame(0, 1'b1);
      idle(3);
      check("gap_pulses", 160'(pulses - p0), 160'd16);
      check("gap_drained", 160'(q.size()), 160'd0);

      // partial frame of 20 beats, then reset, then a full frame
      p0 = pulses;
      for (int k = 0; k < 20; k++) beat(0, k);
      idle(3);
      check("partial_pulses", 160'(pulses - p0), 160'd4);
      reset_pulse(3);
      p0 = pulses;
      send_frame(0, 1'b0);
      idle(3);
      check("after_reset_pulses", 160'(pulses - p0), 160'd16);
      check("after_reset_base", 160'(base_input_idx), 160'd240);

      // extreme values
      p0 = pulses;
      send_frame(2, 1'b0);
      idle(3);
      check("extreme_pulses", 160'(pulses - p0), 160'd16);
      check("extreme_real_a0", 160'(out_real_a[0]), 160'h200);
      check("extreme_imag_a0", 160'(out_imag_a[0]), 160'h1FF);
      check("extreme_real_b15", 160'(out_real_b[15]), 160'h1FF);
      check("extreme_imag_b15", 160'(out_imag_b[15]), 160'h200);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
